// File: rtl/vga_plot_arbiter.sv
// Frame-sequenced owner of the VGA plot port: the background painter runs first each frame,
// then the overlay painter (when enabled), then the port parks until the next V_SYNC fall.
module vga_plot_arbiter (
  input  logic       clk,
  input  logic       iReset,
  input  logic       V_SYNC,
  input  logic       iOverlayEn,
  input  logic       bgValid,
  input  logic [8:0] bgX,
  input  logic [7:0] bgY,
  input  logic [2:0] bgColor,
  input  logic       bgLast,
  output logic       bgReady,
  input  logic       ovValid,
  input  logic [8:0] ovX,
  input  logic [7:0] ovY,
  input  logic [2:0] ovColor,
  input  logic       ovLast,
  output logic       ovReady,
  output logic       oBgStart,
  output logic       oOvStart,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] color,
  output logic       writeEn,
  output logic       oBusy,
  output logic [7:0] oOverrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BG   = 2'd1,
    OV   = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;
  logic   vSyncPrev;
  logic   vSyncFall;
  logic   bgAccept;
  logic   ovAccept;
  logic   bgStartNext;
  logic   ovStartNext;

  // Clipped beats are still consumed, they just never reach the adapter.
  function automatic logic onScreen(input logic [8:0] px, input logic [7:0] py);
    return (px <= 9'd319) && (py <= 8'd239);
  endfunction

  assign vSyncFall = vSyncPrev & ~V_SYNC;
  assign bgAccept  = bgValid & bgReady;
  assign ovAccept  = ovValid & ovReady;

  // Readies and busy derive from state alone so requesters never see a valid->ready loop.
  always_comb begin
    bgReady = 1'b0;
    ovReady = 1'b0;
    oBusy   = 1'b0;
    case (state)
      BG: begin
        bgReady = 1'b1;
        oBusy   = 1'b1;
      end
      OV: begin
        ovReady = 1'b1;
        oBusy   = 1'b1;
      end
      IDLE: begin
        bgReady = 1'b0;
        ovReady = 1'b0;
        oBusy   = 1'b0;
      end
      default: begin
        bgReady = 1'b0;
        ovReady = 1'b0;
        oBusy   = 1'b0;
      end
    endcase
  end

  // Next-state and phase-entry pulses; a V_SYNC fall outside IDLE never restarts a phase.
  always_comb begin
    stateNext   = state;
    bgStartNext = 1'b0;
    ovStartNext = 1'b0;
    case (state)
      IDLE: begin
        if (vSyncFall) begin
          stateNext   = BG;
          bgStartNext = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      BG: begin
        if (bgAccept && bgLast) begin
          if (iOverlayEn) begin
            stateNext   = OV;
            ovStartNext = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end else begin
          stateNext = BG;
        end
      end
      OV: begin
        if (ovAccept && ovLast) begin
          stateNext = IDLE;
        end else begin
          stateNext = OV;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Control registers: state, sync edge history, start pulses and overrun counter.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state     <= IDLE;
      vSyncPrev <= 1'b0;
      oBgStart  <= 1'b0;
      oOvStart  <= 1'b0;
      oOverrun  <= 8'd0;
    end else begin
      state     <= stateNext;
      vSyncPrev <= V_SYNC;
      oBgStart  <= bgStartNext;
      oOvStart  <= ovStartNext;
      if (vSyncFall && (state != IDLE) && (oOverrun != 8'hFF)) begin
        oOverrun <= oOverrun + 8'd1;
      end
    end
  end

  // Plot port registers: one write per accepted on-screen beat.
  always_ff @(posedge clk) begin
    if (iReset) begin
      x       <= 9'd0;
      y       <= 8'd0;
      color   <= 3'd0;
      writeEn <= 1'b0;
    end else if (bgAccept) begin
      x       <= bgX;
      y       <= bgY;
      color   <= bgColor;
      writeEn <= onScreen(bgX, bgY);
    end else if (ovAccept) begin
      x       <= ovX;
      y       <= ovY;
      color   <= ovColor;
      writeEn <= onScreen(ovX, ovY);
    end else begin
      writeEn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomized bench for vga_plot_arbiter: a frame-level phase model plus an in-order
// scoreboard of expected plot writes.
module tb_vga_plot_arbiter;

  logic       clk = 1'b0;
  logic       iReset, V_SYNC, iOverlayEn;
  logic       bgValid, bgLast, ovValid, ovLast;
  logic [8:0] bgX, ovX;
  logic [7:0] bgY, ovY;
  logic [2:0] bgColor, ovColor;
  logic       bgReady, ovReady, oBgStart, oOvStart, writeEn, oBusy;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] color;
  logic [7:0] oOverrun;

  vga_plot_arbiter dut (
    .clk(clk), .iReset(iReset), .V_SYNC(V_SYNC), .iOverlayEn(iOverlayEn),
    .bgValid(bgValid), .bgX(bgX), .bgY(bgY), .bgColor(bgColor), .bgLast(bgLast), .bgReady(bgReady),
    .ovValid(ovValid), .ovX(ovX), .ovY(ovY), .ovColor(ovColor), .ovLast(ovLast), .ovReady(ovReady),
    .oBgStart(oBgStart), .oOvStart(oOvStart), .x(x), .y(y), .color(color),
    .writeEn(writeEn), .oBusy(oBusy), .oOverrun(oOverrun)
  );

  always #5 clk = ~clk;

  localparam int PH_IDLE = 0;
  localparam int PH_BG   = 1;
  localparam int PH_OV   = 2;

  int          mPhase;
  bit          mPrevVs;
  int          mOverrun;
  logic [19:0] expQ[$];
  int          testCount, failCount, wrCount, expWrCount;
  bit          lastBgAcc, lastOvAcc;
  logic [8:0]  lastWrX;
  logic [7:0]  lastWrY;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check state-derived outputs, advance the model, then check registered outputs.
  task automatic tick();
    bit fall, accBg, accOv, expWe, expBgS, expOvS, rst;
    logic [19:0] pix;
    checkVal("bgReady", bgReady, (mPhase == PH_BG));
    checkVal("ovReady", ovReady, (mPhase == PH_OV));
    checkVal("oBusy", oBusy, (mPhase != PH_IDLE));
    accBg = 1'b0; accOv = 1'b0; expWe = 1'b0; expBgS = 1'b0; expOvS = 1'b0;
    rst = iReset;
    if (rst) begin
      mPhase = PH_IDLE; mPrevVs = 1'b0; mOverrun = 0;
    end else begin
      fall  = mPrevVs && !V_SYNC;
      accBg = (mPhase == PH_BG) && bgValid;
      accOv = (mPhase == PH_OV) && ovValid;
      if (accBg && bgX < 320 && bgY < 240) begin
        expWe = 1'b1; expQ.push_back({bgX, bgY, bgColor});
      end
      if (accOv && ovX < 320 && ovY < 240) begin
        expWe = 1'b1; expQ.push_back({ovX, ovY, ovColor});
      end
      if (expWe) expWrCount++;
      if (fall && mPhase != PH_IDLE && mOverrun < 255) mOverrun++;
      if (mPhase == PH_IDLE && fall) begin
        mPhase = PH_BG; expBgS = 1'b1;
      end else if (accBg && bgLast) begin
        if (iOverlayEn) begin mPhase = PH_OV; expOvS = 1'b1; end
        else mPhase = PH_IDLE;
      end else if (accOv && ovLast) begin
        mPhase = PH_IDLE;
      end
      mPrevVs = V_SYNC;
    end
    lastBgAcc = accBg; lastOvAcc = accOv;
    @(posedge clk); #1;
    checkVal("writeEn", writeEn, expWe);
    if (writeEn === 1'b1) begin
      wrCount++; lastWrX = x; lastWrY = y;
      checkVal("wrQueueDepth", expQ.size(), 1);
      if (expQ.size() > 0) begin
        pix = expQ.pop_front();
        checkVal("pixel", {x, y, color}, pix);
      end
    end
    if (rst) checkVal("rstPlot", {x, y, color}, 20'd0);
    checkVal("oBgStart", oBgStart, expBgS);
    checkVal("oOvStart", oOvStart, expOvS);
    checkVal("oOverrun", oOverrun, mOverrun);
  endtask

  task automatic setBg(input int i, input int n, input bit clip);
    bgColor = 3'($urandom_range(7));
    bgLast  = (i == n - 1);
    if (i == n - 1)  begin bgX = 9'd319; bgY = 8'd239; end
    else if (i == 3) begin bgX = 9'd320; bgY = 8'd10;  end
    else if (i == 4) begin bgX = 9'd5;   bgY = 8'd240; end
    else if (clip)   begin bgX = 9'($urandom_range(340)); bgY = 8'($urandom_range(250)); end
    else             begin bgX = 9'($urandom_range(319)); bgY = 8'($urandom_range(239)); end
  endtask

  task automatic setOv(input int i, input int n, input bit clip);
    ovColor = 3'($urandom_range(7));
    ovLast  = (i == n - 1);
    if (clip) begin ovX = 9'($urandom_range(340)); ovY = 8'($urandom_range(250)); end
    else      begin ovX = 9'($urandom_range(319)); ovY = 8'($urandom_range(239)); end
  endtask

  task automatic runFrame(input int nBg, input int nOv, input bit ovEn,
                          input int bgDuty, input int ovDuty, input bit clip);
    int i, guard, wrStart, expStart, expTotal;
    wrStart = wrCount; expStart = expWrCount;
    iOverlayEn = ovEn;
    V_SYNC = 1'b1; tick();
    V_SYNC = 1'b0;
    tick();
    i = 0; guard = 0; setBg(0, nBg, clip);
    while (i < nBg && guard < nBg * 20 + 50) begin
      bgValid = ($urandom_range(99) < bgDuty);
      ovValid = 1'($urandom_range(1)); ovLast = 1'($urandom_range(1));
      ovX = 9'($urandom_range(319)); ovY = 8'($urandom_range(239));
      tick(); guard++;
      if (lastBgAcc) begin i++; if (i < nBg) setBg(i, nBg, clip); end
    end
    checkVal("bgComplete", i, nBg);
    if (ovEn) begin
      i = 0; guard = 0; setOv(0, nOv, clip);
      while (i < nOv && guard < nOv * 20 + 50) begin
        ovValid = ($urandom_range(99) < ovDuty);
        bgValid = 1'($urandom_range(1));
        tick(); guard++;
        if (lastOvAcc) begin i++; if (i < nOv) setOv(i, nOv, clip); end
      end
      checkVal("ovComplete", i, nOv);
    end
    bgValid = 1'b0; ovValid = 1'b0;
    tick(); tick();
    expTotal = clip ? (expWrCount - expStart) : (nBg - 2 + (ovEn ? nOv : 0));
    checkVal("frameWrites", wrCount - wrStart, expTotal);
    if (!ovEn) begin
      checkVal("lastX", lastWrX, 319);
      checkVal("lastY", lastWrY, 239);
    end
  endtask

  task automatic enterBg();
    V_SYNC = 1'b1; tick();
    V_SYNC = 1'b0; tick();
  endtask

  initial begin
    testCount = 0; failCount = 0; wrCount = 0; expWrCount = 0;
    mPhase = PH_IDLE; mPrevVs = 1'b0; mOverrun = 0;
    iReset = 1'b1; V_SYNC = 1'b1; iOverlayEn = 1'b0;
    bgValid = 1'b0; bgLast = 1'b0; bgX = 9'd0; bgY = 8'd0; bgColor = 3'd0;
    ovValid = 1'b0; ovLast = 1'b0; ovX = 9'd0; ovY = 8'd0; ovColor = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    iReset = 1'b0;
    tick();

    // Continuous frames, with and without overlay.
    runFrame(200, 0, 1'b0, 100, 0, 1'b0);
    runFrame(150, 16, 1'b1, 100, 100, 1'b0);

    // Reset in the middle of a background phase with a beat pending.
    enterBg();
    bgValid = 1'b1; bgLast = 1'b0; bgX = 9'd10; bgY = 8'd20; bgColor = 3'd5;
    repeat (5) tick();
    iReset = 1'b1; tick();
    iReset = 1'b0; tick();
    checkVal("postRstBusy", oBusy, 1'b0);
    bgValid = 1'b0;
    runFrame(60, 8, 1'b1, 100, 100, 1'b0);

    // Last background beat coinciding with a V_SYNC fall: overrun, then IDLE.
    iOverlayEn = 1'b0;
    enterBg();
    V_SYNC = 1'b1; tick();
    bgValid = 1'b1; bgLast = 1'b1; bgX = 9'd1; bgY = 8'd2; V_SYNC = 1'b0; tick();
    bgValid = 1'b0; tick();
    checkVal("lastFallOverrun", oOverrun, 8'd1);
    checkVal("lastFallIdle", oBusy, 1'b0);

    // Repeated overruns during one background phase saturate the counter.
    enterBg();
    V_SYNC = 1'b1; tick(); V_SYNC = 1'b0; tick();
    checkVal("overrunOne", oOverrun, 8'd2);
    for (int k = 0; k < 299; k++) begin
      V_SYNC = 1'b1; tick(); V_SYNC = 1'b0; tick();
    end
    checkVal("overrunSat", oOverrun, 8'd255);
    checkVal("overrunStillBg", oBusy, 1'b1);
    bgValid = 1'b1; bgLast = 1'b1; bgX = 9'd100; bgY = 8'd100; tick();
    bgValid = 1'b0; tick(); tick();

    // Randomized valids and clipped coordinates.
    iReset = 1'b1; tick(); iReset = 1'b0; tick();
    runFrame(300, 40, 1'b1, 50, 60, 1'b1);
    runFrame(150, 0, 1'b0, 30, 0, 1'b1);
    runFrame(120, 25, 1'b1, 70, 40, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
